// File: rtl/subneg_pkg.sv
// Shared definitions for the subneg CPU program loader: memory geometry,
// loader state encoding and the checksum accumulate helper.
package subneg_pkg;

  localparam int SN_DATA_W = 5;
  localparam int SN_ADDR_W = 5;
  localparam int SN_DEPTH  = 22;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_VERIFY = 3'd2,
    ST_CMP    = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_t;

  // Running image checksum; wraps naturally at 8 bits.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/subneg_sync_edge.sv
// Pin synchroniser followed by a rising-edge detector producing a one-cycle pulse.
module subneg_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the asynchronous pin through the synchroniser and keep one delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/subneg_prog_loader.sv
// Program memory writer/verifier for the subneg CPU. Accepts one word per host
// strobe, writes (LOAD) or compares against memory (VERIFY), and releases the
// CPU only once a complete, good image is present.
module subneg_prog_loader
  import subneg_pkg::*;
#(
  parameter int DATA_W      = SN_DATA_W,
  parameter int ADDR_W      = SN_ADDR_W,
  parameter int DEPTH       = SN_DEPTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_strobe,
  input  logic              host_start,
  input  logic              host_mode,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_cnt,
  output logic [7:0]        csum
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  loader_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_q;
  logic              wr_pend;
  logic              rd_wait;
  logic              stb_p;
  logic              start_p;

  subneg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (host_strobe),
    .pulse    (stb_p)
  );

  subneg_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (host_start),
    .pulse    (start_p)
  );

  // Capture the host word only when the FSM will actually consume this strobe;
  // a strobe dropped in CMP must not disturb the word under comparison.
  always_ff @(posedge clk) begin
    if (stb_p && ((state == ST_LOAD && !wr_pend) || state == ST_VERIFY)) begin
      data_q <= host_data;
    end
  end

  // Session FSM with registered memory-port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      wr_pend   <= 1'b0;
      rd_wait   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      word_cnt  <= '0;
      csum      <= '0;
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start_p) begin
            addr     <= '0;
            word_cnt <= '0;
            csum     <= '0;
            wr_pend  <= 1'b0;
            rd_wait  <= 1'b0;
            busy     <= 1'b1;
            state    <= host_mode ? ST_LOAD : ST_VERIFY;
          end
        end
        ST_LOAD: begin
          if (wr_pend) begin
            wr_pend   <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= data_q;
            csum      <= csum_add(csum, 8'(data_q));
            word_cnt  <= word_cnt + 1'b1;
            if (addr == LAST_ADDR) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              addr <= addr + 1'b1;
            end
          end else if (stb_p) begin
            wr_pend <= 1'b1;
          end
        end
        ST_VERIFY: begin
          if (stb_p) begin
            mem_addr <= addr;
            rd_wait  <= 1'b1;
            state    <= ST_CMP;
          end
        end
        ST_CMP: begin
          // First cycle lets the synchronous read return; second cycle compares.
          if (rd_wait) begin
            rd_wait <= 1'b0;
          end else if (mem_rdata == data_q) begin
            csum     <= csum_add(csum, 8'(data_q));
            word_cnt <= word_cnt + 1'b1;
            if (addr == LAST_ADDR) begin
              state   <= ST_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_run <= 1'b1;
            end else begin
              addr  <= addr + 1'b1;
              state <= ST_VERIFY;
            end
          end else begin
            state <= ST_ERROR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start_p) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            cpu_run <= 1'b0;
          end
        end
        ST_ERROR: begin
          cpu_run <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
